// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - opcode, FSM state and flag index definitions for accumulator_unit
//
// Shared by accumulator_unit and its testbench.
package acc_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_ADC  = 3'b100;
    localparam logic [2:0] OP_CLR  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit positions inside the packed flag register
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_W = 4;

endpackage

// File: rtl/addsub_core.sv
// rtl/addsub_core.sv - combinational ripple adder with b-invert and carry-in
//
// Ports:
//   i_a, i_b  operands (WIDTH)
//   i_sub     invert i_b before adding (subtract when combined with i_cin=1)
//   i_cin     carry-in
//   o_sum     WIDTH-bit sum
//   o_cout    carry-out of the MSB
//   o_ovf     signed overflow relative to i_a and the effective (possibly inverted) b
module addsub_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_c;

    assign w_b    = i_sub ? ~i_b : i_b;
    assign w_c[0] = i_cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_sum[i]  = i_a[i] ^ w_b[i] ^ w_c[i];
        assign w_c[i+1]  = (i_a[i] & w_b[i]) | (i_a[i] & w_c[i]) | (w_b[i] & w_c[i]);
    end

    assign o_cout = w_c[WIDTH];
    assign o_ovf  = (i_a[WIDTH-1] == w_b[WIDTH-1]) & (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/accumulator_unit.sv
// rtl/accumulator_unit.sv - accumulator with flags, single-cycle ALU ops and shift-add multiply
//
// Optional build macro: ACC_SAT_EN (ADD/SUB/ADC saturate to signed max/min on overflow).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operation handshake; op and operand sampled on accept
//   op, operand           opcode (acc_pkg) and B operand
//   acc                   registered accumulator
//   carry, zero, neg, ovf registered flags
//   out_valid             one-cycle pulse after acc/flags were written
//   busy                  multiply running
module accumulator_unit
    import acc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             out_valid,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [FLAG_W-1:0]  r_flags;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    // Product is kept as the upper half plus the WIDTH-1 low bits still needed;
    // the bit shifted out of the bottom on each step never reaches the result.
    logic [WIDTH-1:0]   r_prod_hi;
    logic [WIDTH-2:0]   r_prod_lo;

    logic               w_accept;
    logic               w_in_ready;
    logic               w_busy;
    logic               w_last;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic               w_sub;
    logic               w_cin;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_arith;
    logic [WIDTH:0]     w_step_hi;
    logic [2*WIDTH-1:0] w_prod_next;

    assign w_accept = in_valid & w_in_ready;
    assign w_last   = (r_cnt == LAST_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        case (r_state)
            ST_MUL: begin
                w_in_ready = 1'b0;
                w_busy     = 1'b1;
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE lasts one cycle
                w_next = ST_IDLE;
                if (in_valid && op == OP_MUL) begin
                    w_next = ST_MUL;
                end
            end
        endcase
    end

    // The single adder serves the ALU ops while idle and the multiply step while busy
    always_comb begin
        w_a   = r_acc;
        w_b   = operand;
        w_sub = 1'b0;
        w_cin = 1'b0;
        if (r_state == ST_MUL) begin
            w_a = r_prod_hi;
            w_b = r_mcand;
        end else if (op == OP_SUB) begin
            w_sub = 1'b1;
            w_cin = 1'b1;
        end else if (op == OP_ADC) begin
            w_cin = r_flags[FLAG_C];
        end
    end

    addsub_core #(.WIDTH(WIDTH)) u_addsub (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_sub  (w_sub),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_ovf  (w_ovf)
    );

`ifdef ACC_SAT_EN
    // Overflow direction follows the sign of A: positive A can only overflow upward
    assign w_arith = !w_ovf        ? w_sum :
                     r_acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                      {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign w_arith = w_sum;
`endif

    // Add the multiplicand into the upper half when the multiplier LSB is set,
    // keeping the adder carry as the bit that shifts into the product MSB.
    assign w_step_hi   = r_mplier[0] ? {w_cout, w_sum} : {1'b0, r_prod_hi};
    assign w_prod_next = {w_step_hi, r_prod_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_flags     <= FLAG_W'(1 << FLAG_Z);
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_prod_hi   <= '0;
            r_prod_lo   <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_state == ST_MUL) begin
                r_prod_hi <= w_prod_next[2*WIDTH-1:WIDTH];
                r_prod_lo <= w_prod_next[WIDTH-1:1];
                r_mplier  <= r_mplier >> 1;
                r_cnt     <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_cnt           <= '0;
                    r_acc           <= w_prod_next[WIDTH-1:0];
                    r_flags[FLAG_C] <= |w_prod_next[2*WIDTH-1:WIDTH];
                    r_flags[FLAG_Z] <= (w_prod_next[WIDTH-1:0] == '0);
                    r_flags[FLAG_N] <= w_prod_next[WIDTH-1];
                    r_flags[FLAG_V] <= 1'b0;
                    r_out_valid     <= 1'b1;
                end
            end else if (w_accept) begin
                case (op)
                    OP_LOAD: begin
                        r_acc           <= operand;
                        r_flags[FLAG_Z] <= (operand == '0);
                        r_flags[FLAG_N] <= operand[WIDTH-1];
                        r_flags[FLAG_V] <= 1'b0;
                        r_out_valid     <= 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_ADC: begin
                        r_acc           <= w_arith;
                        r_flags[FLAG_C] <= w_cout;
                        r_flags[FLAG_Z] <= (w_arith == '0);
                        r_flags[FLAG_N] <= w_arith[WIDTH-1];
                        r_flags[FLAG_V] <= w_ovf;
                        r_out_valid     <= 1'b1;
                    end
                    OP_CLR: begin
                        r_acc       <= '0;
                        r_flags     <= FLAG_W'(1 << FLAG_Z);
                        r_out_valid <= 1'b1;
                    end
                    OP_MUL: begin
                        r_mcand   <= r_acc;
                        r_mplier  <= operand;
                        r_prod_hi <= '0;
                        r_prod_lo <= '0;
                        r_cnt     <= '0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign busy      = w_busy;
    assign acc       = r_acc;
    assign carry     = r_flags[FLAG_C];
    assign zero      = r_flags[FLAG_Z];
    assign neg       = r_flags[FLAG_N];
    assign ovf       = r_flags[FLAG_V];
    assign out_valid = r_out_valid;

endmodule
